uart_tx_8n1: RTL and testbench

- Byte-wide UART transmitter driving the board serial output pin (oUART_TXD) from a 50 MHz clock.
- Serialises 8N1 frames: start bit, 8 data bits LSB first, 1 or 2 stop bits.
- Upstream logic (e.g. a result formatter for the switch/adder datapath) pushes bytes through a valid/ready handshake.
- A one-byte holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_tx_8n1.sv | 127 ++++++++++++
 tb/tb_uart_tx_8n1.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
// state | meaning: IDLE line high | START start bit | DATA 8 data bits LSB first | STOP stop bit(s)
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oUART_TXD,
  output logic       oBUSY
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          hold_full;
  logic          bit_done;

  assign bit_done = (baud_cnt == CNT_LAST);
  assign oBUSY    = (state != S_IDLE) || hold_full;

  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      state     <= S_IDLE;
      oUART_TXD <= 1'b1;
      oREADY    <= 1'b1;
      hold_full <= 1'b0;
      hold      <= 8'h00;
      shift     <= 8'h00;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
    end else begin
      // oREADY mirrors !hold_full, so accept and drain never share an edge
      if (iVALID && oREADY) begin
        hold      <= iDATA;
        hold_full <= 1'b1;
        oREADY    <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          oUART_TXD <= 1'b1;
          baud_cnt  <= '0;
          if (hold_full) begin
            shift     <= hold;
            hold_full <= 1'b0;
            oREADY    <= 1'b1;
            bit_idx   <= 3'd0;
            stop_idx  <= 1'b0;
            oUART_TXD <= 1'b0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bit_done) begin
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            oUART_TXD <= shift[0];
            state     <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              stop_idx  <= 1'b0;
              oUART_TXD <= 1'b1;
              state     <= S_STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift     <= {1'b0, shift[7:1]};
              oUART_TXD <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (stop_idx != STOP_LAST) begin
              stop_idx <= 1'b1;
            end else if (hold_full) begin
              // next start bit directly follows the last stop cycle
              shift     <= hold;
              hold_full <= 1'b0;
              oREADY    <= 1'b1;
              bit_idx   <= 3'd0;
              stop_idx  <= 1'b0;
              oUART_TXD <= 1'b0;
              state     <= S_START;
            end else begin
              oUART_TXD <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          oUART_TXD <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1: three configurations, scoreboard of queued bytes vs decoded line.
module tb_uart_tx_8n1;

  logic       clk;
  logic       rst;
  logic [7:0] data  [3];
  logic       valid [3];
  logic       ready [3];
  logic       txd   [3];
  logic       busy  [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 0;
  logic [7:0] exp_q [$];

  uart_tx_8n1 #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_c4s1 (
    .iCLK_50(clk), .iRST(rst), .iDATA(data[0]), .iVALID(valid[0]),
    .oREADY(ready[0]), .oUART_TXD(txd[0]), .oBUSY(busy[0]));

  uart_tx_8n1 #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_c4s2 (
    .iCLK_50(clk), .iRST(rst), .iDATA(data[1]), .iVALID(valid[1]),
    .oREADY(ready[1]), .oUART_TXD(txd[1]), .oBUSY(busy[1]));

  uart_tx_8n1 u_dflt (
    .iCLK_50(clk), .iRST(rst), .iDATA(data[2]), .iVALID(valid[2]),
    .oREADY(ready[2]), .oUART_TXD(txd[2]), .oBUSY(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Holds iVALID high until the byte is taken; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    data[sel]  = b;
    valid[sel] = 1'b1;
    while (ready[sel] !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 20000), 32'd1);
    exp_q.push_back(b);
    @(negedge clk);
    check("ready_drop", 32'(ready[sel]), 32'd0);
  endtask

  // Decodes one frame sampling every cycle; returns at the negedge after its last stop cycle.
  task automatic recv(input int cpb, input int nstop, output logic [7:0] b, output int t0);
    int n;
    logic v, first, stable, last_busy;
    logic [11:0] bits;
    n = 0;
    while (txd[sel] !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(n < 20000), 32'd1);
    t0 = cyc;
    stable = 1'b1;
    first = 1'b0;
    last_busy = 1'b0;
    bits = '0;
    for (int i = 0; i < 9 + nstop; i++) begin
      for (int j = 0; j < cpb; j++) begin
        v = txd[sel];
        last_busy = busy[sel];
        if (j == 0) first = v;
        else if (v !== first) stable = 1'b0;
        @(negedge clk);
      end
      bits[i] = first;
    end
    check("bit_stable", 32'(stable), 32'd1);
    check("start_bit", 32'(bits[0]), 32'd0);
    for (int k = 0; k < nstop; k++) check("stop_bit", 32'(bits[9+k]), 32'd1);
    check("busy_last_stop", 32'(last_busy), 32'd1);
    b = bits[8:1];
  endtask

  task automatic pop_check(input logic [7:0] got);
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) check("byte", 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic quiet(input int ncyc);
    int lows;
    lows = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (txd[sel] !== 1'b1) lows++;
    end
    check("line_quiet", 32'(lows), 32'd0);
    check("busy_idle", 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    logic [7:0] b1, b2, b3;
    int t1, t2, t3, t_acc, ta1, ta2, n;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data[i]  = 8'h00;
      valid[i] = 1'b0;
    end
    #1;
    check("rst_txd", 32'(txd[0]), 32'd1);
    check("rst_ready", 32'(ready[0]), 32'd1);
    check("rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single 0x55, C=4 S=1
    sel = 0;
    send(8'h55);
    t_acc = cyc;
    valid[0] = 1'b0;
    check("acc_txd_high", 32'(txd[0]), 32'd1);
    check("acc_busy", 32'(busy[0]), 32'd1);
    recv(4, 1, b1, t1);
    check("latency", 32'(t1 - t_acc), 32'd1);
    pop_check(b1);
    check("busy_after_40", 32'(busy[0]), 32'd0);
    quiet(10);

    // 0xA5 then 0x3C back to back
    fork
      begin
        send(8'hA5);
        ta1 = cyc;
        send(8'h3C);
        ta2 = cyc;
        valid[0] = 1'b0;
      end
      begin
        recv(4, 1, b1, t1);
        pop_check(b1);
        recv(4, 1, b2, t2);
        pop_check(b2);
      end
    join
    check("accept_in_start", 32'(ta2 - ta1), 32'd2);
    check("gapless", 32'(t2 - t1), 32'd40);
    check("busy_after_80", 32'(busy[0]), 32'd0);
    quiet(10);

    // three bytes, iVALID held throughout
    fork
      begin
        send(8'h01);
        send(8'h02);
        send(8'h03);
        valid[0] = 1'b0;
      end
      begin
        recv(4, 1, b1, t1);
        pop_check(b1);
        recv(4, 1, b2, t2);
        pop_check(b2);
        recv(4, 1, b3, t3);
        pop_check(b3);
      end
    join
    check("gap_12", 32'(t2 - t1), 32'd40);
    check("gap_23", 32'(t3 - t2), 32'd40);
    quiet(60);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // two stop bits, 0xFF
    sel = 1;
    send(8'hFF);
    t_acc = cyc;
    valid[1] = 1'b0;
    recv(4, 2, b1, t1);
    check("latency_s2", 32'(t1 - t_acc), 32'd1);
    pop_check(b1);
    check("busy_after_44", 32'(busy[1]), 32'd0);
    quiet(10);

    // reset during data bit 3 of 0x0F with 0x77 waiting in hold
    sel = 0;
    fork
      begin
        send(8'h0F);
        send(8'h77);
        valid[0] = 1'b0;
      end
      begin
        n = 0;
        while (txd[0] !== 1'b0 && n < 20000) begin
          @(negedge clk);
          n++;
        end
        check("rst_start_seen", 32'(n < 20000), 32'd1);
        repeat (17) @(negedge clk);
      end
    join
    check("pre_rst_ready", 32'(ready[0]), 32'd0);
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_txd", 32'(txd[0]), 32'd1);
    check("mid_rst_ready", 32'(ready[0]), 32'd1);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    quiet(60);
    send(8'h81);
    t_acc = cyc;
    valid[0] = 1'b0;
    recv(4, 1, b1, t1);
    check("latency_post_rst", 32'(t1 - t_acc), 32'd1);
    pop_check(b1);
    check("busy_post_rst", 32'(busy[0]), 32'd0);

    // default 434 clocks per bit, 0x41
    sel = 2;
    send(8'h41);
    t_acc = cyc;
    valid[2] = 1'b0;
    recv(434, 1, b1, t1);
    check("latency_dflt", 32'(t1 - t_acc), 32'd1);
    pop_check(b1);
    check("frame_4340", 32'(cyc - t1), 32'd4340);
    check("busy_dflt", 32'(busy[2]), 32'd0);
    check("sb_final", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
